// File: rtl/acm_diff_if.sv
// acm_diff_if: sum-in / increment-out stream bundle for acm_diff.
interface acm_diff_if #(
  parameter int unsigned WIDTH = 6
) ();

  logic [WIDTH-1:0] s_in;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] x_out;
  logic             x_valid;
  logic             x_ready;

  // Producer of sums / consumer of increments
  modport master (
    output s_in, s_valid, x_ready,
    input  s_ready, x_out, x_valid
  );

  // The differencer itself
  modport slave (
    input  s_in, s_valid, x_ready,
    output s_ready, x_out, x_valid
  );

endinterface

// File: rtl/acm_diff.sv
// acm_diff: recovers x[n] = s[n] - s[n-1] mod 2^WIDTH from an accumulator's
// running-sum stream, through a 2-entry output buffer, counting deliveries.
module acm_diff #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  acm_diff_if.slave        bus,
  output logic [WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  occ_e             r_occ;
  occ_e             w_occ_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [WIDTH-1:0] r_buf [2];
  logic             r_rd_ptr;
  logic             w_rd_nxt;
  logic             r_wr_ptr;
  logic             w_wr_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_buf_we;
  logic             w_push;
  logic             w_pop;
  logic             w_s_ready;
  logic             w_x_valid;
  logic [WIDTH-1:0] w_diff;

  // Handshake decodes depend only on occupancy, so x_ready never reaches s_ready
  assign w_s_ready   = (r_occ != ST_FULL);
  assign w_x_valid   = (r_occ != ST_EMPTY);
  assign w_push      = bus.s_valid && w_s_ready;
  assign w_pop       = w_x_valid && bus.x_ready;
  assign w_diff      = bus.s_in - r_prev;

  assign bus.s_ready = w_s_ready;
  assign bus.x_valid = w_x_valid;
  assign bus.x_out   = r_buf[r_rd_ptr];
  assign o_count     = r_count;

  // Next-state: occupancy FSM, pointers, previous sum and delivery counter
  always_comb begin
    w_occ_nxt   = r_occ;
    w_prev_nxt  = r_prev;
    w_rd_nxt    = r_rd_ptr;
    w_wr_nxt    = r_wr_ptr;
    w_count_nxt = r_count;
    w_buf_we    = 1'b0;

    if (i_clear) begin
      // Restart wins over any handshake in the same cycle
      w_occ_nxt   = ST_EMPTY;
      w_prev_nxt  = '0;
      w_rd_nxt    = 1'b0;
      w_wr_nxt    = 1'b0;
      w_count_nxt = '0;
    end else begin
      case (r_occ)
        ST_EMPTY: if (w_push) w_occ_nxt = ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop)      w_occ_nxt = ST_FULL;
          else if (!w_push && w_pop) w_occ_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_pop) w_occ_nxt = ST_ONE;
        default:  w_occ_nxt = ST_EMPTY;
      endcase

      if (w_push) begin
        w_buf_we   = 1'b1;
        w_prev_nxt = bus.s_in;
        w_wr_nxt   = ~r_wr_ptr;
      end

      if (w_pop) begin
        w_rd_nxt    = ~r_rd_ptr;
        w_count_nxt = r_count + WIDTH'(1);
      end
    end
  end

  // State registers; reset flushes the buffer at once without waiting for an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ    <= ST_EMPTY;
      r_prev   <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      r_occ    <= w_occ_nxt;
      r_prev   <= w_prev_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_count  <= w_count_nxt;
      if (w_buf_we) r_buf[r_wr_ptr] <= w_diff;
    end
  end

endmodule

// File: tb/tb_acm_diff.sv
// tb_acm_diff: directed stimulus with a scoreboard queue of expected increments.
module tb_acm_diff;

  localparam int unsigned W = 6;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [W-1:0] count;

  acm_diff_if #(.WIDTH(W)) bus ();

  acm_diff #(.WIDTH(W)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus),
    .o_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_prev  = '0;
  logic [W-1:0] m_count = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev  = '0;
    m_count = '0;
  endtask

  // Called at a falling edge: drive inputs, check outputs, update model, advance one cycle
  task automatic cycle(input logic sv, input logic [W-1:0] s, input logic xr, input logic clr);
    logic exp_ready;
    logic exp_valid;
    bus.s_valid = sv;
    bus.s_in    = s;
    bus.x_ready = xr;
    clear       = clr;
    exp_ready   = (q.size() != 2);
    exp_valid   = (q.size() != 0);
    chk("s_ready", 32'(bus.s_ready), 32'(exp_ready));
    chk("x_valid", 32'(bus.x_valid), 32'(exp_valid));
    chk("count", 32'(count), 32'(m_count));
    if (exp_valid) chk("x_out", 32'(bus.x_out), 32'(q[0]));
    if (clr) begin
      model_reset();
    end else begin
      if (exp_valid && xr) begin
        void'(q.pop_front());
        m_count = m_count + W'(1);
      end
      if (sv && exp_ready) begin
        q.push_back(s - m_prev);
        m_prev = s;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] seq [6];
    rst_n       = 1'b0;
    clear       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_in    = '0;
    bus.x_ready = 1'b0;

    // Reset values
    #3;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
    chk("rst_x_out", 32'(bus.x_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    #17;
    rst_n = 1'b1;

    // Basic decode: 0,1,3,6,10,15 -> 0,1,2,3,4,5
    seq = '{6'd0, 6'd1, 6'd3, 6'd6, 6'd10, 6'd15};
    for (int i = 0; i < 6; i++) cycle(1'b1, seq[i], 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("basic_count6", 32'(count), 32'd6);

    // Wrap-around: 62 then 3 -> 62 then 5; then 64 more pops wrap count
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("clr_count", 32'(count), 32'd0);
    cycle(1'b1, 6'd62, 1'b1, 1'b0);
    chk("wrap_x62", 32'(bus.x_out), 32'd62);
    cycle(1'b1, 6'd3, 1'b1, 1'b0);
    chk("wrap_x5", 32'(bus.x_out), 32'd5);
    for (int i = 0; i < 64; i++) cycle(1'b1, W'(i * 5), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_count", 32'(count), 32'd2);

    // Backpressure: 10,20,30 with x_ready low; only two accepted
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 6'd10, 1'b0, 1'b0);
    cycle(1'b1, 6'd20, 1'b0, 1'b0);
    chk("bp_full_ready", 32'(bus.s_ready), 32'd0);
    cycle(1'b1, 6'd30, 1'b0, 1'b0);
    chk("bp_head_stable", 32'(bus.x_out), 32'd10);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_second", 32'(bus.x_out), 32'd10);
    cycle(1'b1, 6'd30, 1'b1, 1'b0);
    chk("bp_reoffer", 32'(bus.x_out), 32'd10);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Gapped input: prev held across idle cycles
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 6'd7, 1'b1, 1'b0);
    chk("gap_x7", 32'(bus.x_out), 32'd7);
    cycle(1'b0, 6'd33, 1'b1, 1'b0);
    cycle(1'b0, 6'd50, 1'b1, 1'b0);
    cycle(1'b1, 6'd12, 1'b1, 1'b0);
    chk("gap_x5", 32'(bus.x_out), 32'd5);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Clear priority over simultaneous push and pop
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 6'd4, 1'b0, 1'b0);
    chk("clrp_head4", 32'(bus.x_out), 32'd4);
    cycle(1'b1, 6'd9, 1'b1, 1'b1);
    chk("clrp_x_valid", 32'(bus.x_valid), 32'd0);
    chk("clrp_count", 32'(count), 32'd0);
    cycle(1'b1, 6'd9, 1'b1, 1'b0);
    chk("clrp_x9", 32'(bus.x_out), 32'd9);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Async reset while full
    cycle(1'b1, 6'd20, 1'b0, 1'b0);
    cycle(1'b1, 6'd25, 1'b0, 1'b0);
    chk("ar_full", 32'(bus.s_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_x_valid", 32'(bus.x_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 6'd5, 1'b1, 1'b0);
    chk("ar_x5", 32'(bus.x_out), 32'd5);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
